sha3_axil_slave: RTL and testbench

SHA3_AXIL_SLAVE -- requirements
Module: sha3_axil_slave

---
 rtl/sha3_axil_slave.sv | 148 ++++++++++++++
 tb/tb_sha3_axil_slave.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sha3_axil_slave.sv
// sha3_axil_slave: AXI4-Lite register front end for a SHA-3 core; define SHA3_AXIL_SLVERR_EN to answer SLVERR on offsets 0x50-0x7F
module sha3_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            core_rst,
    output logic [31:0]                     core_in_data,
    output logic [2:0]                      core_in_nbytes,
    output logic                            core_in_last,
    output logic [1:0]                      core_out_size,
    output logic                            core_in_valid,
    input  logic                            core_in_ready,
    input  logic [511:0]                    core_hash,
    input  logic                            core_hash_valid
);
`ifdef SHA3_AXIL_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_PUSH, W_RESP} w_state_t;
    w_state_t w_state_q, w_state_d;
    logic en_q;
    logic [4:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic wstrb_q, wstrb_d;
    logic [5:0] ctrl_q, ctrl_d;
    logic [1:0] bresp_q, bresp_d;
    logic core_rst_q, core_rst_d;
    logic rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0] rresp_q, rresp_d;
    logic aw_hs, w_hs, ar_hs, fire, ws, busy;
    logic [4:0] wa, ra;
    logic [31:0] wd, rd_val, hash_word;
    logic [3:0] oi;
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB[3:1]};
    assign S_AXI_AWREADY = en_q && (w_state_q == W_IDLE || w_state_q == W_DATA);
    assign S_AXI_WREADY = en_q && (w_state_q == W_IDLE || w_state_q == W_ADDR);
    assign S_AXI_ARREADY = en_q && !rvalid_q;
    assign S_AXI_BVALID = w_state_q == W_RESP;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;
    assign busy = w_state_q == W_PUSH;
    assign core_rst = core_rst_q;
    assign core_in_valid = busy;
    assign core_in_data = wdata_q;
    assign core_in_last = busy && ctrl_q[2];
    assign core_in_nbytes = ctrl_q[2] ? {1'b0, ctrl_q[1:0]} : 3'd4;
    assign core_out_size = ctrl_q[5:4];
    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign wa = (w_state_q == W_ADDR) ? waddr_q : S_AXI_AWADDR[6:2];
    assign wd = (w_state_q == W_DATA) ? wdata_q : S_AXI_WDATA;
    assign ws = (w_state_q == W_DATA) ? wstrb_q : S_AXI_WSTRB[0];
    assign fire = (w_state_q == W_IDLE && aw_hs && w_hs) || (w_state_q == W_ADDR && w_hs) || (w_state_q == W_DATA && aw_hs);
    always_comb begin
        w_state_d = w_state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ctrl_d = ctrl_q;
        bresp_d = bresp_q;
        core_rst_d = 1'b0;
        if (fire) begin
            wdata_d = wd;
            bresp_d = (SLVERR_EN && wa >= 5'd20) ? 2'b10 : 2'b00;
            w_state_d = (wa == 5'd2) ? W_PUSH : W_RESP;
            if (wa == 5'd0 && ws) ctrl_d = wd[5:0] & 6'b110111;
            if (wa == 5'd3 && wd[0]) begin
                core_rst_d = 1'b1;
                ctrl_d = 6'd0;
            end
        end else if (w_state_q == W_IDLE && aw_hs) begin
            waddr_d = S_AXI_AWADDR[6:2];
            w_state_d = W_ADDR;
        end else if (w_state_q == W_IDLE && w_hs) begin
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB[0];
            w_state_d = W_DATA;
        end else if (w_state_q == W_PUSH && core_in_ready) begin
            w_state_d = W_RESP;
        end else if (w_state_q == W_RESP && S_AXI_BREADY) begin
            w_state_d = W_IDLE;
        end
    end
    assign ra = S_AXI_ARADDR[6:2];
    assign oi = ra[3:0] - 4'd4;
    assign hash_word = core_hash[{~oi, 5'b0} +: 32];
    assign rd_val = (ra == 5'd0) ? {26'd0, ctrl_q} :
                    (ra == 5'd1) ? {30'd0, busy, core_hash_valid} :
                    (ra >= 5'd4 && ra < 5'd20) ? hash_word : 32'd0;
    assign rvalid_d = ar_hs ? 1'b1 : (rvalid_q && S_AXI_RREADY) ? 1'b0 : rvalid_q;
    assign rdata_d = ar_hs ? rd_val : rdata_q;
    assign rresp_d = ar_hs ? ((SLVERR_EN && ra >= 5'd20) ? 2'b10 : 2'b00) : rresp_q;
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_q <= W_IDLE;
            en_q <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 1'b0;
            ctrl_q <= 6'd0;
            bresp_q <= 2'b00;
            core_rst_q <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q <= 32'd0;
            rresp_q <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            en_q <= 1'b1;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ctrl_q <= ctrl_d;
            bresp_q <= bresp_d;
            core_rst_q <= core_rst_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end
endmodule

// File: tb/tb_sha3_axil_slave.sv
// tb_sha3_axil_slave: directed AXI4-Lite register tests for sha3_axil_slave
module tb_sha3_axil_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic [6:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic core_rst, core_in_last, core_in_valid, core_in_ready, core_hash_valid;
    logic [31:0] core_in_data;
    logic [2:0] core_in_nbytes;
    logic [1:0] core_out_size;
    logic [511:0] core_hash;
    int checks = 0, failures = 0, rst_pulses = 0, push_cnt = 0, n0;
    logic [35:0] push_rec = '0;
    logic [31:0] data;
    logic [1:0] resp;
`ifdef SHA3_AXIL_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif
    sha3_axil_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .core_rst(core_rst), .core_in_data(core_in_data), .core_in_nbytes(core_in_nbytes),
        .core_in_last(core_in_last), .core_out_size(core_out_size), .core_in_valid(core_in_valid),
        .core_in_ready(core_in_ready), .core_hash(core_hash), .core_hash_valid(core_hash_valid)
    );
    always @(negedge clk) if (core_rst) rst_pulses <= rst_pulses + 1;
    always @(posedge clk) if (core_in_valid && core_in_ready) begin
        push_cnt <= push_cnt + 1;
        push_rec <= {core_in_data, core_in_nbytes, core_in_last};
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic axi_write(input logic [6:0] addr, input logic [31:0] d, input logic [3:0] strb, output logic [1:0] r);
        bit aw_done = 0, w_done = 0, a, w;
        int n = 0;
        awaddr = addr; wdata = d; wstrb = strb; awvalid = 1; wvalid = 1;
        while ((!aw_done || !w_done) && n < 50) begin
            a = awvalid && awready;
            w = wvalid && wready;
            @(negedge clk);
            if (a) begin awvalid = 0; aw_done = 1; end
            if (w) begin wvalid = 0; w_done = 1; end
            n++;
        end
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) check("wr_timeout", bvalid, 1);
        awvalid = 0; wvalid = 0;
        r = bresp;
        @(negedge clk);
    endtask
    task automatic axi_read(input logic [6:0] addr, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        araddr = addr; arvalid = 1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (!rvalid) check("rd_timeout", rvalid, 1);
        d = rdata; r = rresp;
        @(negedge clk);
    endtask
    initial begin
        rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0; awvalid = 0; wvalid = 0; arvalid = 0;
        wdata = 0; wstrb = 0; bready = 1; rready = 1; core_in_ready = 1; core_hash = '0; core_hash_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_outs", {awready, wready, arready, bvalid, rvalid, core_rst, core_in_valid, core_in_last}, 8'b0000_0100);
        check("rst_resp", {bresp, rresp, rdata}, 0);
        rst = 0;
        @(negedge clk);
        check("rel_outs", {awready, wready, arready, core_rst}, 4'b1110);
        axi_write(7'h00, 32'h24, 4'hF, resp); check("ctrl_bresp", resp, 0);
        axi_read(7'h00, data, resp); check("ctrl_rd", data, 32'h24); check("ctrl_rresp", resp, 0);
        check("out_size", core_out_size, 2);
        axi_write(7'h00, 32'hFFFF_FFFF, 4'hF, resp); axi_read(7'h00, data, resp); check("ctrl_mask", data, 32'h37);
        axi_write(7'h00, 32'h0, 4'hE, resp); axi_read(7'h00, data, resp); check("ctrl_strb", data, 32'h37);
        n0 = rst_pulses;
        axi_write(7'h0C, 32'h0, 4'hF, resp); axi_read(7'h00, data, resp); check("cmd0_ctrl", data, 32'h37);
        check("cmd0_rst", rst_pulses - n0, 0);
        axi_write(7'h0C, 32'h1, 4'hF, resp); axi_read(7'h00, data, resp); check("cmd1_ctrl", data, 0);
        check("cmd1_rst", rst_pulses - n0, 1);
        core_in_ready = 0; awaddr = 7'h08; wdata = 32'hDEADBEEF; wstrb = 0; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("push_valid", {core_in_valid, bvalid}, 2'b10);
        check("push_data", core_in_data, 32'hDEADBEEF);
        check("push_nb", {core_in_nbytes, core_in_last}, {3'd4, 1'b0});
        axi_read(7'h04, data, resp); check("busy_status", data, 32'h2);
        @(negedge clk); check("bvalid_wait4", bvalid, 0);
        @(negedge clk); core_in_ready = 1; check("bvalid_wait5", bvalid, 0);
        @(negedge clk); check("bvalid_rise", {bvalid, core_in_valid, bresp}, 4'b1000);
        @(negedge clk); check("bvalid_done", bvalid, 0);
        check("push_cnt1", push_cnt, 1);
        axi_write(7'h00, 32'h06, 4'hF, resp); axi_write(7'h08, 32'h61626300, 4'hF, resp);
        check("last_word", push_rec, {32'h61626300, 3'd2, 1'b1}); check("last_size", core_out_size, 0);
        axi_write(7'h00, 32'h04, 4'hF, resp); axi_write(7'h08, 32'h11223344, 4'h0, resp);
        check("tail0", push_rec, {32'h11223344, 3'd0, 1'b1});
        axi_write(7'h00, 32'h00, 4'hF, resp); axi_write(7'h08, 32'hAABBCCDD, 4'hF, resp);
        check("full_word", push_rec, {32'hAABBCCDD, 3'd4, 1'b0});
        check("push_cnt4", push_cnt, 4);
        for (int n = 0; n < 64; n++) core_hash[511-8*n -: 8] = 8'(n);
        core_hash_valid = 1;
        axi_read(7'h10, data, resp); check("hash_w0", data, 32'h00010203); check("hash_resp", resp, 0);
        axi_read(7'h14, data, resp); check("hash_w1", data, 32'h04050607);
        axi_read(7'h4C, data, resp); check("hash_w15", data, 32'h3C3D3E3F);
        axi_read(7'h13, data, resp); check("hash_lowbits", data, 32'h00010203);
        axi_read(7'h04, data, resp); check("status_hv", data, 32'h1);
        bready = 0; wdata = 32'h11; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        check("w_first", {wready, awready, bvalid}, 3'b010);
        repeat (3) begin @(negedge clk); check("w_wait", {wready, awready, bvalid}, 3'b010); end
        awaddr = 7'h00; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        repeat (4) begin check("b_hold", {bvalid, bresp, awready, wready}, 5'b1_00_00); @(negedge clk); end
        bready = 1;
        @(negedge clk); check("b_done", {bvalid, awready, wready}, 3'b011);
        axi_read(7'h00, data, resp); check("wfirst_ctrl", data, 32'h11);
        awaddr = 7'h00; wdata = 32'h02; wstrb = 4'hF; awvalid = 1; wvalid = 1; araddr = 7'h00; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("rd_prewrite", {rvalid, rdata}, {1'b1, 32'h11});
        @(negedge clk);
        axi_read(7'h00, data, resp); check("rd_postwrite", data, 32'h02);
        axi_read(7'h60, data, resp); check("unmap_rdata", data, 0); check("unmap_rresp", resp, ERR);
        axi_write(7'h60, 32'hFFFF_FFFF, 4'hF, resp); check("unmap_bresp", resp, ERR);
        axi_read(7'h00, data, resp); check("unmap_discard", data, 32'h02);
        axi_read(7'h7C, data, resp); check("unmap_top", {data, resp}, {32'd0, ERR});
        axi_read(7'h08, data, resp); check("rd_input", {data, resp}, 0);
        axi_read(7'h0C, data, resp); check("rd_command", {data, resp}, 0);
        awaddr = 7'h00; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("aw_only", {awready, wready}, 2'b01);
        rst = 1;
        @(negedge clk); check("mid_rst", {awready, wready, bvalid, core_rst}, 4'b0001);
        rst = 0;
        @(negedge clk); check("mid_rel", {awready, wready, bvalid, core_rst}, 4'b1100);
        axi_read(7'h00, data, resp); check("rst_ctrl", data, 0);
        axi_write(7'h00, 32'h30, 4'hF, resp); axi_read(7'h00, data, resp); check("post_rst_wr", data, 32'h30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
